// File: rtl/fetch_hazard_ctrl.sv
// Fetch-side hazard sequencer for the five-stage LEGv8 pipeline.
// Drives PC / IF/ID enables, IF/ID flush and ID/EX bubble insert, resolving
// taken-branch flush > load-use stall > multi-cycle multiply hold, and keeps
// a saturating count of cycles in which the PC was held.
// MUL_LAT is expected in 2..16 so that MUL_LAT-2 fits the 4-bit hold counter.
module fetch_hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31,
  parameter int MUL_LAT  = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_reg_a,
  input  logic [REG_W-1:0] id_reg_b,
  input  logic             id_uses_a,
  input  logic             id_uses_b,
  input  logic             id_mul,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memread,
  input  logic             br_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             mul_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, MUL_WAIT, RELEASE} state_t;

  localparam logic [REG_W-1:0] ZR       = REG_W'(ZERO_REG);
  localparam logic [3:0]       MUL_INIT = 4'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic lu;
  logic pc_w, ifid_w, flush, bubble;

  // Load-use: a load in EX writes a register the ID instruction reads (XZR never counts)
  always_comb begin
    lu = ex_memread && (ex_rd != ZR) &&
         ((id_uses_a && (id_reg_a == ex_rd)) || (id_uses_b && (id_reg_b == ex_rd)));
  end

  // Next-state, hold counter and output class selection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_w    = 1'b1;
    ifid_w  = 1'b1;
    flush   = 1'b0;
    bubble  = 1'b0;
    case (state_q)
      RUN: begin
        if (br_taken) begin
          flush  = 1'b1;
          bubble = 1'b1;
        end else if (lu) begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          bubble = 1'b1;
        end else if (id_mul) begin
          pc_w    = 1'b0;
          ifid_w  = 1'b0;
          bubble  = 1'b1;
          cnt_d   = MUL_INIT;
          state_d = (MUL_LAT == 2) ? RELEASE : MUL_WAIT;
        end
      end
      MUL_WAIT: begin
        if (br_taken) begin
          // Branch wins; the multiply in ID is squashed along with the rest
          flush   = 1'b1;
          bubble  = 1'b1;
          state_d = RUN;
        end else begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          bubble = 1'b1;
          if (cnt_q == 4'd1) state_d = RELEASE;
          else               cnt_d   = cnt_q - 4'd1;
        end
      end
      RELEASE: begin
        // Multiply moves on to EX this cycle; id_mul still refers to it, so ignore it
        if (br_taken) begin
          flush   = 1'b1;
          bubble  = 1'b1;
          state_d = RUN;
        end else if (lu) begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          bubble = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    stall_cycles_d = stall_cycles_q;
    if (!pc_w && (stall_cycles_q != CNT_MAX)) stall_cycles_d = stall_cycles_q + 1'b1;
  end

  // State, hold counter and stall counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= RUN;
      cnt_q          <= 4'd0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // While reset is held the pipeline front end is frozen and flushed
  always_comb begin
    pc_write     = reset & pc_w;
    ifid_write   = reset & ifid_w;
    ifid_flush   = ~reset | flush;
    idex_bubble  = ~reset | bubble;
    mul_busy     = reset & (state_q == MUL_WAIT);
    stall_cycles = stall_cycles_q;
  end

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Scoreboard bench for fetch_hazard_ctrl. Three instances share one input
// bus: default parameters, MUL_LAT=2, and CNT_W=4. Each stimulus cycle pushes
// the hand-computed expectation for one selected instance; a negedge monitor
// pops and compares it.
module tb_fetch_hazard_ctrl;

  localparam logic [3:0] C_FL = 4'b1111;  // {pc_write, ifid_write, ifid_flush, idex_bubble}
  localparam logic [3:0] C_ST = 4'b0001;
  localparam logic [3:0] C_NO = 4'b1100;
  localparam logic [3:0] C_RS = 4'b0011;

  typedef struct {
    int         sel;
    logic [3:0] cls;
    logic       busy;
    logic [15:0] sc;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   errs   = 0;
  int   checks = 0;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_reg_a, id_reg_b, ex_rd;
  logic       id_uses_a, id_uses_b, id_mul, ex_memread, br_taken;

  logic [2:0] pw, iw, fl, bb, mb;
  logic [15:0] sc0, sc1;
  logic [3:0]  sc2;

  always #5 clk = ~clk;

  fetch_hazard_ctrl u_def (
    .clk(clk), .reset(reset), .id_reg_a(id_reg_a), .id_reg_b(id_reg_b),
    .id_uses_a(id_uses_a), .id_uses_b(id_uses_b), .id_mul(id_mul), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .br_taken(br_taken), .pc_write(pw[0]), .ifid_write(iw[0]),
    .ifid_flush(fl[0]), .idex_bubble(bb[0]), .mul_busy(mb[0]), .stall_cycles(sc0));

  fetch_hazard_ctrl #(.MUL_LAT(2)) u_m2 (
    .clk(clk), .reset(reset), .id_reg_a(id_reg_a), .id_reg_b(id_reg_b),
    .id_uses_a(id_uses_a), .id_uses_b(id_uses_b), .id_mul(id_mul), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .br_taken(br_taken), .pc_write(pw[1]), .ifid_write(iw[1]),
    .ifid_flush(fl[1]), .idex_bubble(bb[1]), .mul_busy(mb[1]), .stall_cycles(sc1));

  fetch_hazard_ctrl #(.CNT_W(4)) u_c4 (
    .clk(clk), .reset(reset), .id_reg_a(id_reg_a), .id_reg_b(id_reg_b),
    .id_uses_a(id_uses_a), .id_uses_b(id_uses_b), .id_mul(id_mul), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .br_taken(br_taken), .pc_write(pw[2]), .ifid_write(iw[2]),
    .ifid_flush(fl[2]), .idex_bubble(bb[2]), .mul_busy(mb[2]), .stall_cycles(sc2));

  // Monitor: outputs are settled mid-cycle, compare them against the oldest expectation
  always @(negedge clk) begin
    exp_t        e;
    logic [3:0]  g_cls;
    logic [15:0] g_sc;
    if (exp_q.size() != 0) begin
      e     = exp_q.pop_front();
      g_cls = {pw[e.sel], iw[e.sel], fl[e.sel], bb[e.sel]};
      g_sc  = (e.sel == 0) ? sc0 : (e.sel == 1) ? sc1 : {12'd0, sc2};
      checks++;
      if (g_cls !== e.cls) begin
        errs++;
        $display("FAIL %s dut%0d ctrl got=%b want=%b", e.nm, e.sel, g_cls, e.cls);
      end
      checks++;
      if (mb[e.sel] !== e.busy) begin
        errs++;
        $display("FAIL %s dut%0d mul_busy got=%b want=%b", e.nm, e.sel, mb[e.sel], e.busy);
      end
      checks++;
      if (g_sc !== e.sc) begin
        errs++;
        $display("FAIL %s dut%0d stall_cycles got=%0d want=%0d", e.nm, e.sel, g_sc, e.sc);
      end
    end
  end

  task automatic drv(input logic r, input logic mr, input logic [4:0] rd,
                     input logic [4:0] a, input logic ua, input logic [4:0] b,
                     input logic ub, input logic mul, input logic br);
    reset = r; ex_memread = mr; ex_rd = rd; id_reg_a = a; id_uses_a = ua;
    id_reg_b = b; id_uses_b = ub; id_mul = mul; br_taken = br;
  endtask

  task automatic cyc(input string nm, input int sel, input logic [3:0] cls,
                     input logic busy, input int sc);
    exp_t e;
    e.sel = sel; e.cls = cls; e.busy = busy; e.sc = 16'(sc); e.nm = nm;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    // Reset and release
    repeat (3) cyc("reset", 0, C_RS, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("release", 0, C_NO, 0, 0);

    // Load-use on either source, and the cases that must not stall
    drv(1, 1, 5, 5, 1, 0, 0, 0, 0);   cyc("lu_a", 0, C_ST, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);   cyc("after_lu", 0, C_NO, 0, 1);
    drv(1, 1, 31, 31, 1, 0, 0, 0, 0); cyc("xzr", 0, C_NO, 0, 1);
    drv(1, 1, 5, 5, 0, 0, 0, 0, 0);   cyc("unused_a", 0, C_NO, 0, 1);
    drv(1, 1, 7, 0, 0, 7, 1, 0, 0);   cyc("lu_b", 0, C_ST, 0, 1);
    drv(1, 0, 7, 0, 0, 7, 1, 0, 0);   cyc("no_load", 0, C_NO, 0, 2);

    // Multiply hold, MUL_LAT=4: three stall cycles, busy in cycles 2-3
    drv(1, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("mul1", 0, C_ST, 0, 2);
    cyc("mul2", 0, C_ST, 1, 3);
    cyc("mul3", 0, C_ST, 1, 4);
    cyc("mul_rel", 0, C_NO, 0, 5);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);   cyc("mul_done", 0, C_NO, 0, 5);

    // Branch during the multiply hold abandons it
    drv(1, 0, 0, 0, 0, 0, 0, 1, 0);   cyc("mbr1", 0, C_ST, 0, 5);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1);   cyc("mbr_flush", 0, C_FL, 1, 6);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);   cyc("mbr_after", 0, C_NO, 0, 6);

    // Branch beats load-use, no stall counted
    drv(1, 1, 5, 5, 1, 0, 0, 0, 1);   cyc("lu_br", 0, C_FL, 0, 6);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);   cyc("lu_br_after", 0, C_NO, 0, 6);

    // Load-use in RELEASE stalls there; id_mul in RELEASE is ignored
    drv(1, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("rm1", 0, C_ST, 0, 6);
    cyc("rm2", 0, C_ST, 1, 7);
    cyc("rm3", 0, C_ST, 1, 8);
    drv(1, 1, 9, 9, 1, 0, 0, 0, 0);   cyc("rel_lu", 0, C_ST, 0, 9);
    drv(1, 0, 0, 0, 0, 0, 0, 1, 0);   cyc("rel_ign_mul", 0, C_NO, 0, 10);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);   cyc("rel_run", 0, C_NO, 0, 10);

    // Reset mid-hold: counter cleared before the next edge, back in RUN
    drv(1, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("hold1", 0, C_ST, 0, 10);
    cyc("hold2", 0, C_ST, 1, 11);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);   cyc("hold_rst", 0, C_RS, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);   cyc("post_rst", 0, C_NO, 0, 0);

    // MUL_LAT=2 instance: a single stall cycle
    drv(1, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("m2_1", 1, C_ST, 0, 0);
    cyc("m2_rel", 1, C_NO, 0, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);   cyc("m2_done", 1, C_NO, 0, 1);

    // CNT_W=4 instance: continuous load-use saturates at 15
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);   cyc("c4_rst", 2, C_RS, 0, 0);
    drv(1, 1, 3, 3, 1, 0, 0, 0, 0);
    for (int i = 0; i <= 20; i++) cyc("sat", 2, C_ST, 0, (i > 15) ? 15 : i);
    drv(0, 1, 3, 3, 1, 0, 0, 0, 0);   cyc("sat_rst", 2, C_RS, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);   cyc("c4_post", 2, C_NO, 0, 0);

    // Drain the scoreboard within a bounded number of cycles
    for (int n = 0; n < 10 && exp_q.size() != 0; n++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
